// File: rtl/lsu_pkg.sv
// Shared constants, state type and access-legality helper for the load/store unit.
package lsu_pkg;

    localparam int WIDTH = 32;

    // RISC-V funct3 encodings for memory accesses
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } lsu_state_t;

    // Misaligned halfword/word or an encoding with no meaning for the access kind.
    function automatic logic access_fault(input logic       we,
                                          input logic [2:0] f3,
                                          input logic [1:0] off);
        logic f;
        f = 1'b0;
        if (we) begin
            case (f3)
                F3_B:    f = 1'b0;
                F3_H:    f = off[0];
                F3_W:    f = (off != 2'b00);
                default: f = 1'b1;
            endcase
        end else begin
            case (f3)
                F3_B, F3_BU: f = 1'b0;
                F3_H, F3_HU: f = off[0];
                F3_W:        f = (off != 2'b00);
                default:     f = 1'b1;
            endcase
        end
        return f;
    endfunction

endpackage

// File: rtl/load_store_unit_byte_lane_merge.sv
// Lane steering: inserts store bytes into a memory word and extracts/extends load lanes.
module byte_lane_merge
    import lsu_pkg::*;
(
    input  logic [WIDTH-1:0] old_word_i,
    input  logic [WIDTH-1:0] new_data_i,
    input  logic [2:0]       funct3_i,
    input  logic [1:0]       byte_off_i,
    output logic [WIDTH-1:0] merged_word_o,
    output logic [WIDTH-1:0] load_value_o
);

    logic [4:0]  bit_off;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    assign bit_off   = {byte_off_i, 3'b000};
    assign lane_byte = old_word_i[bit_off +: 8];
    assign lane_half = byte_off_i[1] ? old_word_i[31:16] : old_word_i[15:0];

    // Replace the addressed lane of the old word with the low bits of the store data.
    always_comb begin
        merged_word_o = old_word_i;
        case (funct3_i[1:0])
            2'b00: merged_word_o[bit_off +: 8] = new_data_i[7:0];
            2'b01: begin
                if (byte_off_i[1]) merged_word_o[31:16] = new_data_i[15:0];
                else               merged_word_o[15:0]  = new_data_i[15:0];
            end
            default: merged_word_o = new_data_i;
        endcase
    end

    // Pick the addressed lane and sign- or zero-extend it to a full word.
    always_comb begin
        load_value_o = '0;
        case (funct3_i)
            F3_B:    load_value_o = {{24{lane_byte[7]}}, lane_byte};
            F3_BU:   load_value_o = {24'h0, lane_byte};
            F3_H:    load_value_o = {{16{lane_half[15]}}, lane_half};
            F3_HU:   load_value_o = {16'h0, lane_half};
            F3_W:    load_value_o = old_word_i;
            default: load_value_o = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: combinational loads, single-cycle word stores, and a two-cycle
// read-modify-write for byte/halfword stores against a word-wide data memory.
//
// Handshake: the core presents a request with mem_req=1. The request is accepted at
// the rising edge where stall=0; while stall=1 the core must hold mem_req, mem_we,
// funct3, addr and store_data unchanged. Faulting requests are never stalled.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_req,
    input  logic             mem_we,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] store_data,
    output logic [WIDTH-1:0] load_data,
    output logic             stall,
    output logic             mem_fault,
    output logic             dm_write_read,
    output logic [WIDTH-1:0] dm_address,
    output logic [WIDTH-1:0] dm_write_data,
    input  logic [WIDTH-1:0] dm_read_data
);

    lsu_state_t       state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] merge_q, merge_d;

    logic [WIDTH-1:0] merged_word;
    logic [WIDTH-1:0] lane_load;
    logic             fault;

    byte_lane_merge u_merge (
        .old_word_i    (dm_read_data),
        .new_data_i    (store_data),
        .funct3_i      (funct3),
        .byte_off_i    (addr[1:0]),
        .merged_word_o (merged_word),
        .load_value_o  (lane_load)
    );

    assign fault = access_fault(mem_we, funct3, addr[1:0]);

    // Next-state and output decode; every output is defaulted first.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        merge_d       = merge_q;
        load_data     = '0;
        stall         = 1'b0;
        mem_fault     = 1'b0;
        dm_write_read = 1'b0;
        dm_address    = {2'b00, addr[WIDTH-1:2]};
        dm_write_data = '0;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    if (fault) begin
                        mem_fault = 1'b1;
                    end else if (!mem_we) begin
                        load_data = lane_load;
                    end else if (funct3 == F3_W) begin
                        dm_write_read = 1'b1;
                        dm_write_data = store_data;
                    end else begin
                        // Sub-word store: read this cycle, write merged word next cycle.
                        stall   = 1'b1;
                        merge_d = merged_word;
                        addr_d  = {2'b00, addr[WIDTH-1:2]};
                        state_d = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                // A reset landing here drops the pending write; the core re-executes.
                dm_write_read = ~reset;
                dm_address    = addr_q;
                dm_write_data = merge_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, captured word index and merged word registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            merge_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            merge_q <= merge_d;
        end
    end

endmodule
